// File: rtl/motor_ramp_pwm.sv
// Multi-channel motor PWM generator with slew-limited duty ramping.
// Each channel ramps its duty toward a latched target in bounded steps on a
// slow tick. A shared free-running counter generates the PWM periods.
// Compare thresholds are reloaded only at the period wrap, so a duty change
// never produces a runt pulse.
module motor_ramp_pwm #(
  parameter int CH       = 2,
  parameter int DW       = 10,
  parameter int PERIOD   = 4000,
  parameter int STEP_DIV = 100000,
  parameter int STEP     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [CH*DW-1:0]   target,
  input  logic               load,
  output logic [CH-1:0]      pwm,
  output logic [CH*DW-1:0]   duty_cur,
  output logic [CH-1:0]      at_target,
  output logic               period_start
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(STEP_DIV + 1);
  localparam int PW = DW + CW;
  localparam logic [DW-1:0]        DMAX   = {DW{1'b1}};
  localparam logic signed [DW:0]   STEP_S = (DW+1)'(STEP);
  localparam logic [CW-1:0]        CLAST  = CW'(PERIOD - 1);
  localparam logic [TW-1:0]        TLAST  = TW'(STEP_DIV - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tdiv_q, tdiv_d;
  logic [CH-1:0][DW-1:0]   tgt_q, tgt_d;
  logic [CH-1:0][DW-1:0]   duty_q, duty_d;
  logic [CH-1:0][CW-1:0]   thr_q, thr_d;
  logic [CH-1:0]           pwm_q, pwm_d;
  logic                    tick;
  logic                    wrap;

  // Move cur toward tgt by at most STEP; a signed DW+1 bit difference covers
  // the full range, and the result always lies between cur and tgt.
  function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] tgt);
    logic signed [DW:0] diff;
    logic signed [DW:0] nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)
      nxt = $signed({1'b0, cur}) + STEP_S;
    else if (diff < -STEP_S)
      nxt = $signed({1'b0, cur}) - STEP_S;
    else
      nxt = $signed({1'b0, tgt});
    return nxt[DW-1:0];
  endfunction

  // Map duty to a high-cycle count per period; full-scale duty means always on.
  function automatic logic [CW-1:0] duty_to_thr(input logic [DW-1:0] d);
    logic [PW-1:0] prod;
    prod = PW'(d) * PW'(PERIOD);
    if (d == DMAX)
      return CW'(PERIOD);
    return CW'(prod >> DW);
  endfunction

  assign wrap = (cnt_q == CLAST);
  assign tick = (tdiv_q == TLAST);

  // Next-state logic for counters, targets, ramped duty, thresholds and PWM.
  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tdiv_d = tick ? '0 : tdiv_q + 1'b1;
    tgt_d  = load ? target : tgt_q;
    duty_d = duty_q;
    thr_d  = thr_q;
    pwm_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (!en)
        duty_d[i] = '0;
      else if (tick)
        duty_d[i] = ramp_step(duty_q[i], tgt_q[i]);
      if (wrap)
        thr_d[i] = duty_to_thr(duty_q[i]);
      pwm_d[i] = en & (cnt_q < thr_q[i]);
    end
  end

  // State registers; reset discards ramp progress and idles the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tdiv_q <= '0;
      tgt_q  <= '0;
      duty_q <= '0;
      thr_q  <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tdiv_q <= tdiv_d;
      tgt_q  <= tgt_d;
      duty_q <= duty_d;
      thr_q  <= thr_d;
      pwm_q  <= pwm_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    for (int i = 0; i < CH; i++)
      at_target[i] = (duty_q[i] == tgt_q[i]);
  end

  assign period_start = (cnt_q == '0);
  assign duty_cur     = duty_q;
  assign pwm          = pwm_q;

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Randomised bench for motor_ramp_pwm against a cycle-level arithmetic model.
module tb_motor_ramp_pwm;
  localparam int CH     = 2;
  localparam int DW     = 10;
  localparam int PERIOD = 16;
  localparam int SD     = 4;
  localparam int STEP   = 64;
  localparam int DMAX   = 1023;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               load;
  logic [CH*DW-1:0]   target;
  logic [CH-1:0]      pwm;
  logic [CH*DW-1:0]   duty_cur;
  logic [CH-1:0]      at_target;
  logic               period_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (plain integers).
  int m_cnt, m_tdiv;
  int m_tgt  [CH];
  int m_duty [CH];
  int m_thr  [CH];
  int m_pwm  [CH];

  motor_ramp_pwm #(.CH(CH), .DW(DW), .PERIOD(PERIOD), .STEP_DIV(SD), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .target(target), .load(load),
    .pwm(pwm), .duty_cur(duty_cur), .at_target(at_target), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_tdiv = 0;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0; m_duty[i] = 0; m_thr[i] = 0; m_pwm[i] = 0;
    end
  endtask

  // One rising edge of the model, using pre-edge state throughout.
  task automatic model_edge(input bit e, input bit ld, input int t0, input int t1);
    int tin [CH];
    int d;
    bit tick;
    tin[0] = t0;
    tin[1] = t1;
    tick = (m_tdiv == SD - 1);
    for (int i = 0; i < CH; i++) begin
      m_pwm[i] = (e && (m_cnt < m_thr[i])) ? 1 : 0;
      if (m_cnt == PERIOD - 1)
        m_thr[i] = (m_duty[i] == DMAX) ? PERIOD : (m_duty[i] * PERIOD) / (DMAX + 1);
      if (!e)
        m_duty[i] = 0;
      else if (tick) begin
        d = m_tgt[i] - m_duty[i];
        if (d > STEP) d = STEP;
        if (d < -STEP) d = -STEP;
        m_duty[i] = m_duty[i] + d;
      end
      if (ld) m_tgt[i] = tin[i];
    end
    m_cnt  = (m_cnt + 1) % PERIOD;
    m_tdiv = (m_tdiv + 1) % SD;
  endtask

  task automatic compare_outputs();
    logic [CH-1:0] ep, ea;
    for (int i = 0; i < CH; i++) begin
      ep[i] = (m_pwm[i] != 0);
      ea[i] = (m_duty[i] == m_tgt[i]);
    end
    check_eq("duty0", 64'(duty_cur[DW-1:0]), 64'(m_duty[0]));
    check_eq("duty1", 64'(duty_cur[2*DW-1:DW]), 64'(m_duty[1]));
    check_eq("pwm", 64'(pwm), 64'(ep));
    check_eq("at_target", 64'(at_target), 64'(ea));
    check_eq("period_start", 64'(period_start), 64'(m_cnt == 0));
  endtask

  task automatic cyc(input bit e, input bit ld, input int t0, input int t1);
    en = e;
    load = ld;
    target = {DW'(t1), DW'(t0)};
    @(posedge clk);
    model_edge(e, ld, t0, t1);
    #1;
    compare_outputs();
  endtask

  // Assert reset between edges and confirm outputs respond without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      compare_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int seq[$];
    int prev;
    int hi0, hi1;
    bit found;
    int r, t0, t1;
    bit e, ld;

    rst_n = 1'b0; en = 1'b0; load = 1'b0; target = '0;
    #3;
    model_reset();
    compare_outputs();
    @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;

    // Ramp ch0 to 200 and ch1 to 512.
    cyc(1, 1, 200, 512);
    prev = 0;
    for (int k = 0; k < 59; k++) begin
      cyc(1, 0, 200, 512);
      if (int'(duty_cur[DW-1:0]) != prev) begin
        prev = int'(duty_cur[DW-1:0]);
        seq.push_back(prev);
      end
    end
    check_eq("ramp_len", 64'(seq.size()), 64'd4);
    if (seq.size() >= 4) begin
      check_eq("ramp_s0", 64'(seq[0]), 64'd64);
      check_eq("ramp_s1", 64'(seq[1]), 64'd128);
      check_eq("ramp_s2", 64'(seq[2]), 64'd192);
      check_eq("ramp_s3", 64'(seq[3]), 64'd200);
    end

    // Half duty on ch1: count high cycles over one period.
    found = 0;
    for (int k = 0; k < PERIOD + 1 && !found; k++) begin
      cyc(1, 0, 200, 512);
      if (period_start) found = 1;
    end
    check_eq("ps_found", 64'(found), 64'd1);
    hi0 = 0; hi1 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc(1, 0, 200, 512);
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
    end
    check_eq("hi_cnt_512", 64'(hi1), 64'd8);
    check_eq("hi_cnt_200", 64'(hi0), 64'd3);

    // Full-scale ch0 stays on, zero ch1 stays off.
    cyc(1, 1, DMAX, 0);
    for (int k = 0; k < 99; k++) cyc(1, 0, DMAX, 0);
    hi0 = 0; hi1 = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      cyc(1, 0, DMAX, 0);
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
    end
    check_eq("full_on", 64'(hi0), 64'(2 * PERIOD));
    check_eq("full_off", 64'(hi1), 64'd0);

    // Drop enable mid-period, then re-enable and ramp again.
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check_eq("en_off_pwm", 64'(pwm), 64'd0);
    check_eq("en_off_duty", 64'(duty_cur), 64'd0);
    for (int k = 0; k < 30; k++) cyc(1, 0, 0, 0);

    // Reset in the middle of a ramp.
    cyc(1, 1, 300, 700);
    for (int k = 0; k < 9; k++) cyc(1, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1, (k == 3), 400, 100);

    // Randomised operation.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 3);
      t0 = (r == 0) ? 0 : (r == 1) ? DMAX : int'($urandom_range(0, DMAX));
      r = $urandom_range(0, 3);
      t1 = (r == 0) ? 0 : (r == 1) ? DMAX : int'($urandom_range(0, DMAX));
      e  = ($urandom_range(0, 31) != 0);
      ld = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0)
        do_reset();
      else
        cyc(e, ld, t0, t1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
